// File: rtl/video_pkg.sv
// Shared video definitions for the receive path.
// Holds the receiver FSM state type, the 640x480 reference timing constants
// and the 12-bit {r,g,b} pixel type. No ports.
package video_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } rx_state_t;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 525;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/sync_edge.sv
// Registers one stream control signal, normalises it to active-high and
// produces single-cycle rise/fall pulses against the previous registered copy.
// Ports:
//   clk_i   pixel clock
//   rst_ni  asynchronous active-low reset
//   sig_i   raw input level
//   level_o registered, normalised level (1 = asserted)
//   rise_o  asserted this cycle, not asserted last cycle
//   fall_o  not asserted this cycle, asserted last cycle
module sync_edge #(
    parameter bit POL = 1'b1  // input level that means "asserted"
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic prev_q;

    // Reset to "not asserted" so an idle stream produces no edge after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= sig_i ~^ POL;
            prev_q  <= level_q;
        end
    end

    always_comb begin
        level_o = level_q;
        rise_o  = level_q & ~prev_q;
        fall_o  = ~level_q & prev_q;
    end

endmodule

// File: rtl/video_timing_rx.sv
// Video stream receiver: rebuilds active-area coordinates from hsync/vsync/de,
// measures active width, active height and line period, and locks once the
// stream matches the expected resolution for LOCK_FRAMES consecutive frames.
// Ports:
//   clk_i, rst_ni              pixel clock, asynchronous active-low reset
//   hsync_i, vsync_i, de_i     raw stream controls (sync level set by SYNC_POL)
//   rgb_i                      12-bit {r,g,b} pixel
//   de_o, pix_o, sx_o, sy_o    2-cycle delayed pixel and its coordinates, gated by lock
//   frame_o                    pulse with pixel (0,0) while locked
//   locked_o, err_o            lock status, sticky loss-of-lock flag
//   h_act_o, v_act_o, h_tot_o  last measured width, height and line period
module video_timing_rx #(
    parameter int unsigned CORDW       = 10,
    parameter int unsigned H_RES       = video_pkg::H_RES,
    parameter int unsigned V_RES       = video_pkg::V_RES,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [11:0]      rgb_i,
    output logic             de_o,
    output logic [11:0]      pix_o,
    output logic [CORDW-1:0] sx_o,
    output logic [CORDW-1:0] sy_o,
    output logic             frame_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [CORDW-1:0] h_act_o,
    output logic [CORDW-1:0] v_act_o,
    output logic [CORDW:0]   h_tot_o
);
    import video_pkg::*;

    localparam logic [CORDW-1:0] CMAX   = '1;
    localparam logic [CORDW:0]   TMAX   = '1;
    localparam logic [CORDW-1:0] HRES_C = CORDW'(H_RES);
    localparam logic [CORDW-1:0] VRES_C = CORDW'(V_RES);
    localparam logic [3:0]       LOCK_C = 4'(LOCK_FRAMES);

    logic hs, hs_rise, hs_fall;
    logic vs, vs_rise, vs_fall;
    logic de, de_rise, de_fall;
    logic unused_edges;

    rgb12_t           rgb1;
    logic [CORDW-1:0] pix_cnt, line_cnt, line_total;
    logic [CORDW:0]   htot_cnt;
    logic             bad_seen;  // bad line or de-in-vsync since the last vsync edge
    logic             line_bad, frame_good;

    rx_state_t state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       err_q, err_d;

    sync_edge #(.POL(SYNC_POL)) u_hs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (hsync_i),
        .level_o(hs),
        .rise_o (hs_rise),
        .fall_o (hs_fall)
    );

    sync_edge #(.POL(SYNC_POL)) u_vs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (vsync_i),
        .level_o(vs),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    sync_edge #(.POL(1'b1)) u_de (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (de_i),
        .level_o(de),
        .rise_o (de_rise),
        .fall_o (de_fall)
    );

    assign unused_edges = ^{hs, hs_fall, vs_fall, de_rise};

    // A line closing on the same cycle as the vsync edge still counts toward this frame.
    always_comb begin
        line_bad   = de_fall && (pix_cnt != HRES_C);
        line_total = (de_fall && line_cnt != CMAX) ? line_cnt + 1'b1 : line_cnt;
        frame_good = (line_total == VRES_C) && !bad_seen && !line_bad && !de;
    end

    // Stage 1: pixel register, counters and measurements.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb1     <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            htot_cnt <= '0;
            h_act_o  <= '0;
            v_act_o  <= '0;
            h_tot_o  <= '0;
            bad_seen <= 1'b0;
        end else begin
            rgb1 <= rgb_i;

            if (de_fall) begin
                pix_cnt <= '0;
                h_act_o <= pix_cnt;
            end else if (de && pix_cnt != CMAX) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (vs_rise) begin
                line_cnt <= '0;
                v_act_o  <= line_total;
            end else if (de_fall && line_cnt != CMAX) begin
                line_cnt <= line_cnt + 1'b1;
            end

            // Count is one short of the period at the edge, hence the +1 on latch.
            if (hs_rise) begin
                htot_cnt <= '0;
                h_tot_o  <= (htot_cnt == TMAX) ? TMAX : htot_cnt + 1'b1;
            end else if (htot_cnt != TMAX) begin
                htot_cnt <= htot_cnt + 1'b1;
            end

            if (vs_rise) begin
                bad_seen <= 1'b0;
            end else if (line_bad || (de && vs)) begin
                bad_seen <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
            good_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    // FSM next state: all decisions are taken at the vsync assertion edge.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = TRAIN;
                    good_d  = '0;
                end
            end
            TRAIN: begin
                if (vs_rise) begin
                    if (frame_good) begin
                        good_d = good_q + 1'b1;
                        if (good_d >= LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (vs_rise && !frame_good) begin
                    state_d = TRAIN;
                    good_d  = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        locked_o = (state_q == LOCKED);
        err_o    = err_q;
    end

    // Stage 2: gated pixel output; coordinates hold while de_o is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            de_o    <= 1'b0;
            pix_o   <= '0;
            sx_o    <= '0;
            sy_o    <= '0;
            frame_o <= 1'b0;
        end else begin
            de_o    <= de && locked_o;
            pix_o   <= rgb1;
            frame_o <= de && locked_o && (pix_cnt == '0) && (line_cnt == '0);
            if (de && locked_o) begin
                sx_o <= pix_cnt;
                sy_o <= line_cnt;
            end
        end
    end

endmodule
